// File: rtl/apb_pkg.sv
// Shared APB completer types and bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

  localparam int APB_DW   = 32;
  localparam int APB_AW   = 32;
  localparam int APB_NSEL = 3;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_slv_state_t;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master) and one completer (slave).
// Latency: n/a (wires only).
// Backpressure: completer stalls the master by holding Pready low.
interface apb_slave_mem_if;
  import apb_pkg::*;

  logic [APB_NSEL-1:0] Pselx;
  logic                Penable;
  logic                Pwrite;
  logic [APB_AW-1:0]   Paddr;
  logic [APB_DW-1:0]   Pwdata;
  logic [APB_DW-1:0]   Prdata;
  logic                Pready;
  logic                Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );

endinterface

// File: rtl/apb_slave_storage.sv
// DEPTH x 32-bit word store with one shared index for read and write.
// Latency: combinational read of the current contents, write lands on the next edge.
// Backpressure: none; the caller decides when wr_en is asserted.
module apb_slave_storage #(
  parameter  int DEPTH = 16,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wr_dat,
  output logic [31:0]   rd_dat
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  // Next contents: hold, or replace the addressed word on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[idx] = wr_dat;
    end
  end

  // Word array; synchronous reset clears every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read returns the pre-write value when a write hits the same edge.
  assign rd_dat = mem_q[idx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer serving word reads/writes from a local array, with bad-address error.
// Latency: 2 + WAIT_STATES cycles per transfer, all outputs registered.
// Backpressure: Pready held low for WAIT_STATES ACCESS cycles; master must hold the bus.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int          SLV_ID      = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0
) (
  input  logic             Pclk,
  input  logic             Presetn,
  apb_slave_mem_if.slave   bus,
  output logic             proto_err
);

  localparam int                  IW       = $clog2(DEPTH);
  localparam logic [APB_AW-1:0]   END_ADDR = BASE_ADDR + APB_AW'(4 * DEPTH);
  localparam logic [3:0]          WS       = 4'(WAIT_STATES);
  localparam logic [APB_NSEL-1:0] SEL_MASK = APB_NSEL'(1) << SLV_ID;

  apb_slv_state_t    state_q, state_d;
  logic [APB_AW-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              proto_err_q, proto_err_d;

  logic              sel;
  logic              addr_err;
  logic [IW-1:0]     idx;
  logic [APB_DW-1:0] rd_dat;
  logic              mem_we;
  logic [APB_DW-1:0] rsp_dat;

  // A select on any other Pselx bit looks exactly like no select.
  assign sel      = |(bus.Pselx & SEL_MASK);
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) || (addr_q >= END_ADDR);
  assign idx      = IW'((addr_q - BASE_ADDR) >> 2);
  // Errored transfers and writes return zero read data.
  assign rsp_dat  = (addr_err || write_q) ? '0 : rd_dat;

  apb_slave_storage #(.DEPTH(DEPTH)) u_storage (
    .clk    (Pclk),
    .rst_n  (Presetn),
    .wr_en  (mem_we),
    .idx    (idx),
    .wr_dat (wdata_q),
    .rd_dat (rd_dat)
  );

  // Transfer FSM: capture in IDLE, arm wait counter in SETUP, count and complete in ACCESS.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    prdata_d    = prdata_q;
    pready_d    = pready_q;
    pslverr_d   = pslverr_q;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;
    unique case (state_q)
      APB_IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (sel && !bus.Penable) begin
          state_d = APB_SETUP;
          addr_d  = bus.Paddr;
          write_d = bus.Pwrite;
          wdata_d = bus.Pwdata;
        end else if (sel && bus.Penable) begin
          proto_err_d = 1'b1;
        end
      end
      APB_SETUP: begin
        state_d = APB_ACCESS;
        cnt_d   = WS;
        if (WS == 4'd0) begin
          pready_d  = 1'b1;
          pslverr_d = addr_err;
          prdata_d  = rsp_dat;
        end
      end
      APB_ACCESS: begin
        if (cnt_q != 4'd0) begin
          if (!sel || !bus.Penable) begin
            // Master walked away mid-transfer: drop it without touching memory.
            state_d     = APB_IDLE;
            proto_err_d = 1'b1;
            pready_d    = 1'b0;
            pslverr_d   = 1'b0;
            prdata_d    = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              pready_d  = 1'b1;
              pslverr_d = addr_err;
              prdata_d  = rsp_dat;
            end
          end
        end else begin
          // Pready is high this cycle: commit the write and clear the response.
          mem_we    = write_q && !addr_err;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
          if (sel && !bus.Penable) begin
            state_d = APB_SETUP;
            addr_d  = bus.Paddr;
            write_d = bus.Pwrite;
            wdata_d = bus.Pwdata;
          end else begin
            state_d = APB_IDLE;
          end
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  // State, capture and output registers with synchronous active-low reset.
  always_ff @(posedge Pclk) begin
    if (!Presetn) begin
      state_q     <= APB_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.Prdata  = prdata_q;
  assign bus.Pready  = pready_q;
  assign bus.Pslverr = pslverr_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Three completers on one shared APB bus (SLV_ID 0/1/2, wait states 0/3/2),
// driven by a simple master task; expected responses queued at issue, popped at Pready.
module tb_apb_slave_mem;

  logic        Pclk;
  logic        Presetn;
  logic [2:0]  psel;
  logic        pen;
  logic        pwr;
  logic [31:0] paddr;
  logic [31:0] pwdata;

  logic        rdy  [3];
  logic        err  [3];
  logic [31:0] rdat [3];
  logic        perr [3];

  apb_slave_mem_if if0 ();
  apb_slave_mem_if if1 ();
  apb_slave_mem_if if2 ();

  assign if0.Pselx = psel;  assign if0.Penable = pen;  assign if0.Pwrite = pwr;
  assign if0.Paddr = paddr; assign if0.Pwdata = pwdata;
  assign if1.Pselx = psel;  assign if1.Penable = pen;  assign if1.Pwrite = pwr;
  assign if1.Paddr = paddr; assign if1.Pwdata = pwdata;
  assign if2.Pselx = psel;  assign if2.Penable = pen;  assign if2.Pwrite = pwr;
  assign if2.Paddr = paddr; assign if2.Pwdata = pwdata;

  assign rdy[0] = if0.Pready; assign err[0] = if0.Pslverr; assign rdat[0] = if0.Prdata;
  assign rdy[1] = if1.Pready; assign err[1] = if1.Pslverr; assign rdat[1] = if1.Prdata;
  assign rdy[2] = if2.Pready; assign err[2] = if2.Pslverr; assign rdat[2] = if2.Prdata;

  apb_slave_mem #(.SLV_ID(0), .WAIT_STATES(0)) dut0 (
    .Pclk(Pclk), .Presetn(Presetn), .bus(if0.slave), .proto_err(perr[0]));
  apb_slave_mem #(.SLV_ID(1), .WAIT_STATES(3)) dut1 (
    .Pclk(Pclk), .Presetn(Presetn), .bus(if1.slave), .proto_err(perr[1]));
  apb_slave_mem #(.SLV_ID(2), .WAIT_STATES(2)) dut2 (
    .Pclk(Pclk), .Presetn(Presetn), .bus(if2.slave), .proto_err(perr[2]));

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  typedef struct {
    bit          wr;
    logic [31:0] dat;
    bit          err;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] model_mem [3][16];
  int          ws_tab [3] = '{0, 3, 2};
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h8000_0000) || (a >= 32'h8000_0040);
  endfunction

  // Full master transfer: SETUP, ACCESS until Pready, leaves bus in completion cycle.
  task automatic xfer(input int s, input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    exp_t got_e;
    int   waits;
    bit   done;
    bit   bad;
    bad   = addr_bad(a);
    e.wr  = wr;
    e.err = bad;
    e.dat = (!wr && !bad) ? model_mem[s][a[5:2]] : 32'h0;
    if (wr && !bad) model_mem[s][a[5:2]] = d;
    sb_q.push_back(e);
    @(posedge Pclk); #1;
    psel = 3'(1 << s); pen = 1'b0; pwr = wr; paddr = a; pwdata = d;
    @(posedge Pclk); #1;
    pen = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge Pclk); #1;
      for (int o = 0; o < 3; o++) begin
        if (o != s) chk("unselected_rdy", rdy[o], 1'b0);
      end
      if (rdy[s]) done = 1'b1;
      else        waits++;
    end
    chk("pready_seen", done, 1'b1);
    got_e = sb_q.pop_front();
    if (done) begin
      chk("pslverr", err[s], got_e.err);
      if (!got_e.wr) chk("prdata", rdat[s], got_e.dat);
      chk("wait_cycles", waits, ws_tab[s]);
    end
  endtask

  // Release the bus; the completion edge just passed so Pready must be low again.
  task automatic bus_idle();
    @(posedge Pclk); #1;
    psel = 3'b000; pen = 1'b0;
    for (int o = 0; o < 3; o++) chk("rdy_after_done", rdy[o], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    Presetn = 1'b0; psel = 3'b000; pen = 1'b0; pwr = 1'b0; paddr = '0; pwdata = '0;
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 16; w++) model_mem[s][w] = 32'h0;

    // Reset state
    repeat (2) @(posedge Pclk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_pready", rdy[s], 1'b0);
      chk("rst_pslverr", err[s], 1'b0);
      chk("rst_prdata", rdat[s], 32'h0);
      chk("rst_proto_err", perr[s], 1'b0);
    end
    Presetn = 1'b1;

    // All words read back zero after reset
    for (int w = 0; w < 16; w++) xfer(0, 1'b0, 32'h8000_0000 + 32'(4 * w), 32'h0);
    bus_idle();

    // Write then read, zero wait states
    xfer(0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h8000_0008, 32'h0);
    bus_idle();

    // Three wait states on slave 1
    xfer(1, 1'b1, 32'h8000_0004, 32'h1357_9BDF);
    xfer(1, 1'b0, 32'h8000_0004, 32'h0);
    bus_idle();

    // Bad addresses: out of range (aliases word 0), misaligned (word 1), below base
    xfer(0, 1'b1, 32'h8000_0040, 32'h1111_1111);
    xfer(0, 1'b1, 32'h8000_0006, 32'h2222_2222);
    xfer(0, 1'b1, 32'h7FFF_FFFC, 32'h3333_3333);
    xfer(0, 1'b0, 32'h8000_0044, 32'h0);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0);
    xfer(0, 1'b0, 32'h8000_0004, 32'h0);
    xfer(0, 1'b0, 32'h8000_0008, 32'h0);
    bus_idle();

    // Pselx=010 belongs to slave 1 only; slave 0 must stay silent and unchanged
    xfer(1, 1'b1, 32'h8000_0000, 32'hCAFE_0001);
    bus_idle();
    xfer(0, 1'b0, 32'h8000_0000, 32'h0);
    xfer(1, 1'b0, 32'h8000_0000, 32'h0);
    bus_idle();
    chk("no_proto_err_yet", perr[0], 1'b0);

    // Penable without a preceding SETUP on slave 0
    @(posedge Pclk); #1;
    psel = 3'b001; pen = 1'b1;
    @(posedge Pclk); #1;
    psel = 3'b000; pen = 1'b0;
    chk("proto_err_no_setup", perr[0], 1'b1);
    chk("no_setup_rdy", rdy[0], 1'b0);
    chk("proto_err_other", perr[2], 1'b0);

    // Penable dropped in the first ACCESS cycle of a write on slave 2
    @(posedge Pclk); #1;
    psel = 3'b100; pen = 1'b0; pwr = 1'b1; paddr = 32'h8000_0010; pwdata = 32'h1234_5678;
    @(posedge Pclk); #1;
    pen = 1'b1;
    @(posedge Pclk); #1;
    chk("abort_wait_rdy", rdy[2], 1'b0);
    pen = 1'b0;
    @(posedge Pclk); #1;
    psel = 3'b000;
    chk("proto_err_abort", perr[2], 1'b1);
    chk("abort_rdy", rdy[2], 1'b0);
    repeat (2) @(posedge Pclk);

    // Aborted write left no trace; back-to-back transfers still work
    xfer(2, 1'b0, 32'h8000_0010, 32'h0);
    xfer(2, 1'b1, 32'h8000_0014, 32'hA5A5_0001);
    xfer(2, 1'b0, 32'h8000_0014, 32'h0);
    xfer(0, 1'b1, 32'h8000_003C, 32'h0F0F_F0F0);
    xfer(0, 1'b0, 32'h8000_003C, 32'h0);
    bus_idle();
    chk("proto_err_sticky0", perr[0], 1'b1);
    chk("proto_err_sticky2", perr[2], 1'b1);
    chk("proto_err_clean1", perr[1], 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
